// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: per-channel FSM state
// encodings and default debounce timing constants.
package input_debouncer_pkg;

  // Gray-style encoding: a single bit flips on every legal transition.
  typedef enum logic [1:0] {
    IDLE0 = 2'b00,
    WAIT1 = 2'b01,
    IDLE1 = 2'b11,
    WAIT0 = 2'b10
  } db_state_t;

  localparam int DEF_DB_CYCLES = 4;
  localparam int DEF_CNT_W     = 3;

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce channel: two-flop synchroniser feeding a four-state
// accept/reject FSM with a stability counter. Produces a clean level
// plus registered one-cycle rise/fall pulses aligned with the level change.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  // Counter value on the last sample before a new level is accepted.
  // The first matching sample is taken in the IDLE state, so the count
  // stops at DB_CYCLES-1 and never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; only s2 is safe to use downstream.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce FSM: any return to the old level restarts the count; pulses
  // default low so each one lasts exactly one cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE0: begin
          if (s2) begin
            state <= WAIT1;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        WAIT1: begin
          if (!s2) begin
            state <= IDLE0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE1;
            clean <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE1: begin
          if (!s2) begin
            state <= WAIT0;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        WAIT0: begin
          if (s2) begin
            state <= IDLE1;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE0;
            clean <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Input conditioning front end: N_CH independent debounce channels that
// turn raw pushbutton/switch lines into clean levels and edge pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  // One identical channel per input bit; no interaction between channels.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .CLK   (CLK),
      .reset (reset),
      .raw   (raw_in[i]),
      .clean (clean_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer (N_CH=2, DB_CYCLES=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_input_debouncer;

  logic       CLK;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;

  int errors;
  int checks;

  input_debouncer #(
    .N_CH      (2),
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    raw_in = 2'b00;
    step();
    step();
    checks++;
    if (clean_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_clean: got %b want 00", clean_out);
    end
    checks++;
    if ((rise_pulse | fall_pulse) !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses: got rise=%b fall=%b want 00/00", rise_pulse, fall_pulse);
    end
    #2 reset = 1'b0;
    step();
  endtask

  // Channel 0 rises: edge 6 after the change; then falls the same way.
  task automatic test_single_rise();
    logic [1:0] exp_clean;
    logic [1:0] exp_rise;
    logic [1:0] exp_fall;
    raw_in = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_clean = (e >= 6) ? 2'b01 : 2'b00;
      exp_rise  = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if (clean_out !== exp_clean || rise_pulse !== exp_rise || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL single_rise e=%0d: got clean=%b rise=%b fall=%b want %b/%b/00",
                 e, clean_out, rise_pulse, fall_pulse, exp_clean, exp_rise);
      end
    end
    raw_in = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_clean = (e >= 6) ? 2'b00 : 2'b01;
      exp_fall  = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if (clean_out !== exp_clean || fall_pulse !== exp_fall || rise_pulse !== 2'b00) begin
        errors++;
        $display("FAIL single_fall e=%0d: got clean=%b rise=%b fall=%b want %b/00/%b",
                 e, clean_out, rise_pulse, fall_pulse, exp_clean, exp_fall);
      end
    end
  endtask

  // Three-cycle high on channel 1 is shorter than the debounce window.
  task automatic test_glitch();
    raw_in = 2'b10;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) raw_in = 2'b00;
      checks++;
      if (clean_out !== 2'b00 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL glitch e=%0d: got clean=%b rise=%b fall=%b want 00/00/00",
                 e, clean_out, rise_pulse, fall_pulse);
      end
    end
  endtask

  // Sequence 1,1,0,1,0,1 then held: last 0->1 is before edge 6, rise at edge 11.
  task automatic test_chatter();
    logic [5:0] seq;
    logic       exp_clean;
    logic       exp_rise;
    int         rises;
    seq    = 6'b101011;
    rises  = 0;
    raw_in = {1'b0, seq[0]};
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e < 6) raw_in = {1'b0, seq[e]};
      if (rise_pulse[0] === 1'b1) rises++;
      exp_clean = (e >= 11);
      exp_rise  = (e == 11);
      checks++;
      if (clean_out[0] !== exp_clean || rise_pulse[0] !== exp_rise) begin
        errors++;
        $display("FAIL chatter e=%0d: got clean0=%b rise0=%b want %b/%b",
                 e, clean_out[0], rise_pulse[0], exp_clean, exp_rise);
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL chatter_rise_count: got %0d want 1", rises);
    end
    raw_in = 2'b00;
    for (int e = 1; e <= 8; e++) step();
    checks++;
    if (clean_out !== 2'b00) begin
      errors++;
      $display("FAIL chatter_return: got clean=%b want 00", clean_out);
    end
  endtask

  // Both channels together: rise at edge 6, release before edge 11, fall at edge 16.
  task automatic test_simultaneous();
    logic [1:0] exp_clean;
    logic [1:0] exp_rise;
    logic [1:0] exp_fall;
    raw_in = 2'b11;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 10) raw_in = 2'b00;
      exp_clean = (e >= 6 && e < 16) ? 2'b11 : 2'b00;
      exp_rise  = (e == 6)  ? 2'b11 : 2'b00;
      exp_fall  = (e == 16) ? 2'b11 : 2'b00;
      checks++;
      if (clean_out !== exp_clean || rise_pulse !== exp_rise || fall_pulse !== exp_fall) begin
        errors++;
        $display("FAIL simultaneous e=%0d: got clean=%b rise=%b fall=%b want %b/%b/%b",
                 e, clean_out, rise_pulse, fall_pulse, exp_clean, exp_rise, exp_fall);
      end
    end
  endtask

  // Reach clean=11, then assert reset between edges: immediate clear, no fall.
  task automatic test_async_reset();
    raw_in = 2'b11;
    for (int e = 1; e <= 6; e++) step();
    checks++;
    if (clean_out !== 2'b11) begin
      errors++;
      $display("FAIL async_pre: got clean=%b want 11", clean_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (clean_out !== 2'b00 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
      errors++;
      $display("FAIL async_immediate: got clean=%b rise=%b fall=%b want 00/00/00",
               clean_out, rise_pulse, fall_pulse);
    end
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (clean_out !== 2'b00 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL async_held e=%0d: got clean=%b rise=%b fall=%b want 00/00/00",
                 e, clean_out, rise_pulse, fall_pulse);
      end
    end
    raw_in = 2'b00;
    #2 reset = 1'b0;
    for (int e = 1; e <= 4; e++) step();
  endtask

  // Reset after edge 4 of a pending rise; first post-reset edge is 5, rise at edge 10.
  task automatic test_reset_wait1();
    logic exp_clean;
    logic exp_rise;
    raw_in = 2'b01;
    for (int e = 1; e <= 4; e++) step();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    for (int e = 5; e <= 12; e++) begin
      step();
      exp_clean = (e >= 10);
      exp_rise  = (e == 10);
      checks++;
      if (clean_out[0] !== exp_clean || rise_pulse[0] !== exp_rise || clean_out[1] !== 1'b0) begin
        errors++;
        $display("FAIL reset_wait1 e=%0d: got clean=%b rise=%b want clean0=%b rise0=%b",
                 e, clean_out, rise_pulse, exp_clean, exp_rise);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_chatter();
    test_simultaneous();
    test_async_reset();
    test_reset_wait1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
